serial_digit_adder: RTL

Parametrised multi-cycle adder/subtractor for the RSA peripheral datapath. It adds or subtracts two WIDTH-bit operands one DIGIT-bit slice per clock, rippling the carry through a single registered carry flop. This replaces wide single-cycle ripple chains of full adders in the modular-arithmetic path, trading latency for area. A start/busy/done handshake lets the RSA sequencer issue operations and collect results.

---
 rtl/serial_digit_adder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per clock, carry rippled
// through a single registered carry flop, with a start/busy/done handshake.
module serial_digit_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DW   = DIGIT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic             co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_shift;

  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(carry_q);

  // New digits enter at the top so digit 0 ends up at the LSBs after NDIG shifts.
  generate
    if (DIGIT == WIDTH) begin : g_single_digit
      assign res_shift = digit_sum[DIGIT-1:0];
    end else begin : g_multi_digit
      assign res_shift = {digit_sum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so the carry flop seeds the +1.
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          mode_d  = sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
          co_d    = mode_q ? ~digit_sum[DIGIT] : digit_sum[DIGIT];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == RUN) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign co     = co_q;

endmodule
